// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// APB3 initiator. Command requests are queued in a small FIFO. Each request
// is issued on the APB bus as one SETUP phase followed by one or more ACCESS
// phases. Exactly one response per request comes back on a valid/ready
// port, in request order.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : an ACCESS phase that waits TIMEOUT_CYCLES cycles with
//               pready_i low is aborted. The response reports err=1 and
//               rdata=0, and timeout_o pulses for one cycle.
//   undefined : ACCESS waits indefinitely for pready_i and timeout_o is 0.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_write_i/addr/wdata   request payload
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o, rsp_err_o   response payload (rdata is 0 for writes)
//   psel_o ... pslverr_i     APB3 initiator interface
//   timeout_o                one-cycle pulse when a transfer is aborted
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  output logic                  timeout_o
);

  localparam int PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic                  fifo_write_q [REQ_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [REQ_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [REQ_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  ready_en_q;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic                  load_head, capture, abort, cnt_clr;
  logic                  timeout_hit;

  assign fifo_full   = (count_q == CNT_W'(REQ_DEPTH));
  assign fifo_empty  = (count_q == '0);
  // ready_en_q keeps req_ready_o low while reset is asserted and through
  // the first edge after release.
  assign req_ready_o = ready_en_q & ~fifo_full;
  assign push        = req_valid_i & req_ready_o;

  // The APB strobes and the response valid are decoded straight from the
  // state register. This makes them drop as soon as reset is asserted.
  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign rsp_valid_o = (state_q == RESP);

  // FIFO storage. No reset is needed: an entry is read only after it has
  // been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_write_q[wr_ptr_q] <= req_write_i;
      fifo_addr_q[wr_ptr_q]  <= req_addr_i;
      fifo_wdata_q[wr_ptr_q] <= req_wdata_i;
    end
  end

  // FIFO pointers and occupancy. REQ_DEPTH is a power of two, so the
  // pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A transfer pops its FIFO entry when it completes,
  // so in RESP the FIFO head is already the next request.
  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    cnt_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_head = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          capture = 1'b1;
          pop     = 1'b1;
          state_d = RESP;
        end else if (timeout_hit) begin
          abort   = 1'b1;
          pop     = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            load_head = 1'b1;
            state_d   = SETUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the APB address, direction and data when a transfer starts.
  // The values stay stable until the next transfer is latched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      pwdata_o <= '0;
    end else if (load_head) begin
      paddr_o  <= fifo_addr_q[rd_ptr_q];
      pwrite_o <= fifo_write_q[rd_ptr_q];
      pwdata_o <= fifo_write_q[rd_ptr_q] ? fifo_wdata_q[rd_ptr_q] : '0;
    end
  end

  // Response registers. These hold their values while the response waits
  // for rsp_ready_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else if (capture) begin
      rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
      rsp_err_o   <= pslverr_i;
    end else if (abort) begin
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b1;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o   = timeout_q;

  // The counter holds the number of ACCESS cycles already spent waiting.
  // The limit is reached on the TIMEOUT_CYCLES-th ACCESS cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (cnt_clr) begin
        to_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !pready_i) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end
`else
  logic timeout_unused;

  assign timeout_hit    = 1'b0;
  assign timeout_o      = 1'b0;
  assign timeout_unused = (TIMEOUT_CYCLES == 0) | cnt_clr | abort;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master
// Directed testbench for apb_cmd_master. Each scenario task drives its own
// stimulus and compares the DUT outputs against hand-computed values.
// A small APB slave model supplies prdata_i and pslverr_i.
module tb_apb_cmd_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;
  logic        timeout_o;

  logic        slave_mode;
  logic        err_mode;
  logic [31:0] prdata_reg;
  logic        pslverr_reg;

  int checks = 0;
  int failures = 0;

  // With slave_mode set, read data is derived from the address of the
  // current transfer, so that response ordering can be checked.
  // With err_mode set, every write ACCESS reports pslverr.
  assign prdata_i  = slave_mode ? (paddr_o ^ 32'h5A5A_0000) : prdata_reg;
  assign pslverr_i = err_mode ? (pwrite_o & penable_o) : pslverr_reg;

  always #5 clk_i = ~clk_i;

  apb_cmd_master #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .REQ_DEPTH     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i),
    .timeout_o  (timeout_o)
  );

  // Drive one request and wait for it to be accepted. The task returns
  // 1 ns after the handshake edge.
  task automatic push_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output bit accepted);
    logic ready_now;
    accepted    = 1'b0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = data;
    for (int n = 0; n < 50; n++) begin
      ready_now = req_ready_o;
      @(posedge clk_i);
      #1;
      if (ready_now) begin
        accepted = 1'b1;
        break;
      end
    end
    req_valid_i = 1'b0;
  endtask

  // Wait until a response is valid. The wait is bounded at 40 cycles.
  task automatic wait_rsp(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (rsp_valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
  endtask

  // Accept the current response with a one-cycle rsp_ready_i pulse.
  task automatic consume_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    pready_i    = 1'b1;
    slave_mode  = 1'b0;
    err_mode    = 1'b0;
    prdata_reg  = '0;
    pslverr_reg = 1'b0;
    #12;
    checks++;
    if ({req_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o, timeout_o, rsp_err_o} !== 7'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {req_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o, timeout_o, rsp_err_o});
    end
    checks++;
    if ({paddr_o, pwdata_o, rsp_rdata_o} !== 96'b0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h %h %h expected zeros", paddr_o, pwdata_o, rsp_rdata_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b expected 1", req_ready_o);
    end
  endtask

  task automatic test_single_write();
    bit ok;
    pready_i = 1'b1;
    push_req(1'b1, 32'h1A10_0008, 32'h0000_1234, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL wr_accept: got 0 expected 1");
    end
    checks++;
    if (psel_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wr_idle_psel: got %b expected 0", psel_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== {3'b101, 32'h1A10_0008, 32'h0000_1234}) begin
      failures++;
      $display("[TB] FAIL wr_setup: got %b%b%b %h %h expected 101 1a100008 00001234",
               psel_o, penable_o, pwrite_o, paddr_o, pwdata_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({psel_o, penable_o, rsp_valid_o, pwdata_o} !== {3'b110, 32'h0000_1234}) begin
      failures++;
      $display("[TB] FAIL wr_access: got %b%b%b %h expected 110 00001234",
               psel_o, penable_o, rsp_valid_o, pwdata_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({rsp_valid_o, psel_o, rsp_err_o, rsp_rdata_o} !== {3'b100, 32'h0}) begin
      failures++;
      $display("[TB] FAIL wr_rsp: got %b%b%b %h expected 100 00000000",
               rsp_valid_o, psel_o, rsp_err_o, rsp_rdata_o);
    end
    consume_rsp();
    checks++;
    if (rsp_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wr_rsp_drop: got %b expected 0", rsp_valid_o);
    end
  endtask

  task automatic test_read_wait_states();
    bit ok;
    pready_i    = 1'b0;
    prdata_reg  = 32'hCAFE_0001;
    pslverr_reg = 1'b1;
    push_req(1'b0, 32'h1A10_0004, 32'hFFFF_FFFF, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL rd_accept: got 0 expected 1");
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({psel_o, penable_o, pwrite_o, pwdata_o} !== {3'b100, 32'h0}) begin
      failures++;
      $display("[TB] FAIL rd_setup: got %b%b%b %h expected 100 00000000",
               psel_o, penable_o, pwrite_o, pwdata_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if ({psel_o, penable_o, rsp_valid_o, paddr_o} !== {3'b110, 32'h1A10_0004}) begin
        failures++;
        $display("[TB] FAIL rd_wait%0d: got %b%b%b %h expected 110 1a100004",
                 i, psel_o, penable_o, rsp_valid_o, paddr_o);
      end
    end
    pready_i    = 1'b1;
    pslverr_reg = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {2'b10, 32'hCAFE_0001}) begin
      failures++;
      $display("[TB] FAIL rd_rsp: got %b%b %h expected 10 cafe0001",
               rsp_valid_o, rsp_err_o, rsp_rdata_o);
    end
    consume_rsp();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit seen;
    logic [31:0] exp_rdata;
    pready_i    = 1'b0;
    rsp_ready_i = 1'b0;
    slave_mode  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_req(1'b0, 32'h4000_0100 + 32'(i * 4), 32'h0, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL b2b_accept%0d: got 0 expected 1", i);
      end
    end
    checks++;
    if (req_ready_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_full: got %b expected 0", req_ready_o);
    end
    pready_i = 1'b1;
    push_req(1'b0, 32'h4000_0110, 32'h0, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL b2b_accept4: got 0 expected 1");
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({rsp_valid_o, psel_o, penable_o} !== 3'b100) begin
        failures++;
        $display("[TB] FAIL b2b_resp_hold%0d: got %b%b%b expected 100",
                 c, rsp_valid_o, psel_o, penable_o);
      end
      @(posedge clk_i);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      exp_rdata = (32'h4000_0100 + 32'(i * 4)) ^ 32'h5A5A_0000;
      wait_rsp(seen);
      checks++;
      if (!seen || rsp_rdata_o !== exp_rdata || rsp_err_o !== 1'b0 || psel_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_rsp%0d: got valid=%b rdata=%h err=%b psel=%b expected valid=1 rdata=%h err=0 psel=0",
                 i, seen, rsp_rdata_o, rsp_err_o, psel_o, exp_rdata);
      end
      consume_rsp();
    end
    checks++;
    if ({req_ready_o, rsp_valid_o, psel_o} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL b2b_drain: got %b%b%b expected 100", req_ready_o, rsp_valid_o, psel_o);
    end
    slave_mode = 1'b0;
  endtask

  task automatic test_slave_error();
    bit ok;
    bit seen;
    pready_i   = 1'b1;
    err_mode   = 1'b1;
    prdata_reg = 32'h1111_2222;
    push_req(1'b1, 32'h1A10_000C, 32'hAAAA_5555, ok);
    push_req(1'b0, 32'h1A10_0010, 32'h0, ok);
    wait_rsp(seen);
    checks++;
    if (!seen || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      failures++;
      $display("[TB] FAIL err_wr_rsp: got valid=%b err=%b rdata=%h expected valid=1 err=1 rdata=00000000",
               seen, rsp_err_o, rsp_rdata_o);
    end
    consume_rsp();
    wait_rsp(seen);
    checks++;
    if (!seen || rsp_err_o !== 1'b0 || rsp_rdata_o !== 32'h1111_2222) begin
      failures++;
      $display("[TB] FAIL err_rd_rsp: got valid=%b err=%b rdata=%h expected valid=1 err=0 rdata=11112222",
               seen, rsp_err_o, rsp_rdata_o);
    end
    consume_rsp();
    err_mode = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    pready_i   = 1'b0;
    prdata_reg = 32'hDEAD_BEEF;
    push_req(1'b0, 32'h1A10_0020, 32'h0, ok);
    @(posedge clk_i);
    #1;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int j = 0; j < 8; j++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if ({penable_o, timeout_o, rsp_valid_o} !== 3'b100) begin
        failures++;
        $display("[TB] FAIL to_wait%0d: got %b%b%b expected 100", j, penable_o, timeout_o, rsp_valid_o);
      end
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({psel_o, rsp_valid_o, rsp_err_o, timeout_o, rsp_rdata_o} !== {4'b0111, 32'h0}) begin
      failures++;
      $display("[TB] FAIL to_abort: got %b%b%b%b %h expected 0111 00000000",
               psel_o, rsp_valid_o, rsp_err_o, timeout_o, rsp_rdata_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if ({timeout_o, rsp_valid_o} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL to_pulse: got %b%b expected 01", timeout_o, rsp_valid_o);
    end
    pready_i = 1'b1;
`else
    for (int j = 0; j < 20; j++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if ({penable_o, timeout_o, rsp_valid_o} !== 3'b100) begin
        failures++;
        $display("[TB] FAIL nto_wait%0d: got %b%b%b expected 100", j, penable_o, timeout_o, rsp_valid_o);
      end
    end
    pready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if ({rsp_valid_o, rsp_err_o, timeout_o, rsp_rdata_o} !== {3'b100, 32'hDEAD_BEEF}) begin
      failures++;
      $display("[TB] FAIL nto_rsp: got %b%b%b %h expected 100 deadbeef",
               rsp_valid_o, rsp_err_o, timeout_o, rsp_rdata_o);
    end
`endif
    consume_rsp();
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    bit seen;
    pready_i = 1'b0;
    push_req(1'b1, 32'h1A10_0030, 32'h0000_0055, ok);
    push_req(1'b1, 32'h1A10_0034, 32'h0000_0066, ok);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (penable_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL rst_reach_access: got 0 expected 1");
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({psel_o, penable_o} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL rst_async_drop: got %b%b expected 00", psel_o, penable_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni   = 1'b1;
    pready_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, psel_o} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL rst_release: got %b%b%b expected 100", req_ready_o, rsp_valid_o, psel_o);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if ({psel_o, rsp_valid_o} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL rst_flushed%0d: got %b%b expected 00", c, psel_o, rsp_valid_o);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wait_states();
    test_back_to_back();
    test_slave_error();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator that turns queued software/DMA-style command requests into APB3 transfers toward memory-mapped peripherals such as the actuator controller.
- Requests enter through a valid/ready port into a small request FIFO.
- An FSM drives SETUP and ACCESS phases, honouring pready/pslverr wait states.
- Results return on a valid/ready response port, one response per request, in order.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
REQ_DEPTH, 4, request FIFO entries; power of 2, ≥2
TIMEOUT_CYCLES, 256, ACCESS-phase wait limit; used only with APB_MASTER_TIMEOUT_EN

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_write_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  target address
req_wdata_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes
rsp_err_o  out  1  pslverr or timeout
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
paddr_o  out  ADDR_WIDTH  APB address
pwdata_o  out  DATA_WIDTH  APB write data
prdata_i  in  DATA_WIDTH  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error
timeout_o  out  1  one-cycle pulse on transfer abort

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE. req_ready_o becomes 1 on the first cycle after reset release.
- Reset asserted mid-transfer: psel_o and penable_o drop immediately (asynchronous). FIFO is flushed. Any pending response is discarded.
- FIFO:
  - req_ready_o = !full; it does not depend on a same-cycle pop.
  - A push while full is impossible by construction.
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - Pointers wrap modulo REQ_DEPTH.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: if FIFO non-empty → SETUP. On that edge, latch the head entry into paddr_o, pwrite_o and pwdata_o (pwdata_o = 0 for reads).
  - SETUP: psel_o=1, penable_o=0. Go to ACCESS unconditionally.
  - ACCESS: psel_o=1, penable_o=1. Address, write and data outputs are held stable.
    - pready_i=0 → stay in ACCESS.
    - pready_i=1 → capture prdata_i (reads only; writes capture 0) and pslverr_i into the response registers, pop the FIFO, drop psel_o/penable_o, go to RESP.
  - RESP: rsp_valid_o=1; hold rsp_rdata_o and rsp_err_o stable.
    - Handshake with FIFO non-empty → SETUP (back-to-back); the next head is latched on the same edge.
    - Handshake with FIFO empty → IDLE.
    - No handshake → stay in RESP. The APB bus stays idle, so responses are never lost.
- Latency, handshake at edge k with FSM idle and FIFO empty:
  - IDLE→SETUP at edge k+1; SETUP→ACCESS at edge k+2.
  - With pready_i=1 in the first ACCESS cycle, rsp_valid_o rises at edge k+3.
  - Each wait state adds 1 cycle.
- psel_o is never asserted in IDLE or RESP.
- penable_o is only ever high in ACCESS, which is always preceded by exactly one SETUP cycle.
- pslverr_i is ignored unless pready_i=1.
- Responses are returned strictly in request order.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - A counter clears on SETUP→ACCESS and increments each ACCESS cycle with pready_i=0.
  - At count == TIMEOUT_CYCLES-1 with pready_i still 0, the transfer is aborted: psel_o/penable_o drop, the FIFO pops, response is rdata=0, err=1, timeout_o pulses for 1 cycle, and the FSM goes to RESP.
  - If pready_i=1 on the limit cycle, normal completion wins.
- Undefined: no counter; ACCESS waits indefinitely; timeout_o is tied to 0.

Test Plan:
- Single write, addr 0x1A10_0008, data 0x0000_1234, pready_i=1 → SETUP at k+1, ACCESS at k+2, pwdata_o=0x1234 held; rsp_valid_o at k+3, rdata=0, err=0.
- Read, addr 0x1A10_0004, prdata_i=0xCAFE_0001, pready_i low for 3 ACCESS cycles → psel/penable/paddr stable for 4 ACCESS cycles; rsp_rdata_o=0xCAFE_0001 at k+6.
- Push 5 requests back-to-back with REQ_DEPTH=4 and rsp_ready_i=0 → req_ready_o=0 after 4 accepted; responses arrive in order, with no APB activity while in RESP.
- Write with pslverr_i=1, pready_i=1 → rsp_err_o=1; the next queued read completes with err=0.
- Async reset mid-ACCESS → psel_o/penable_o drop before the next edge; after release, FIFO empty, rsp_valid_o=0, req_ready_o=1.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready_i held 0 → abort after 8 ACCESS cycles; timeout_o pulses once; rsp err=1, rdata=0.
